// File: rtl/vedic_mul_seq_if.sv
// Operand/product handshake bundle for vedic_mul_seq.
// signed_mode exists only when VEDIC_SIGNED_EN is defined.
interface vedic_mul_seq_if #(parameter int W = 16);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
    logic           busy;
`ifdef VEDIC_SIGNED_EN
    logic           signed_mode;

    modport master (output in_valid, a, b, signed_mode, out_ready,
                    input  in_ready, out_valid, p, busy);
    modport slave  (input  in_valid, a, b, signed_mode, out_ready,
                    output in_ready, out_valid, p, busy);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, p, busy);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, p, busy);
`endif
endinterface

// File: rtl/vedic_mul_seq.sv
// Sequential multiplier: one (W/2)x(W/2) Vedic core reused over four quadrant cycles.
// Define VEDIC_SIGNED_EN to add two's-complement operation via bus.signed_mode.

module vedic_cell2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] z
);
    logic c1;
    assign z[0] = x[0] & y[0];
    assign z[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    assign c1   = (x[1] & y[0]) & (x[0] & y[1]);
    assign z[2] = (x[1] & y[1]) ^ c1;
    assign z[3] = (x[1] & y[1]) & c1;
endmodule

module vedic_rca #(parameter int N = 4) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] s
);
    logic [N-1:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i] = x[i] ^ y[i] ^ c[i];
        if (i < N-1) begin : g_c
            assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end
endmodule

module vedic_core #(parameter int N = 8) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] z
);
    if (N == 2) begin : g_leaf
        vedic_cell2 u_cell (.x(x), .y(y), .z(z));
    end else begin : g_rec
        localparam int H = N/2;
        logic [N-1:0]   ll, hl, lh, hh;
        logic [N:0]     mid;
        logic [2*N-1:0] mid_sh;

        vedic_core #(.N(H)) u_ll (.x(x[H-1:0]), .y(y[H-1:0]), .z(ll));
        vedic_core #(.N(H)) u_hl (.x(x[N-1:H]), .y(y[H-1:0]), .z(hl));
        vedic_core #(.N(H)) u_lh (.x(x[H-1:0]), .y(y[N-1:H]), .z(lh));
        vedic_core #(.N(H)) u_hh (.x(x[N-1:H]), .y(y[N-1:H]), .z(hh));

        // hh and ll occupy disjoint bit ranges, so only the cross terms need adding
        vedic_rca #(.N(N+1)) u_mid (.x({1'b0, hl}), .y({1'b0, lh}), .s(mid));
        assign mid_sh = {{(H-1){1'b0}}, mid, {H{1'b0}}};
        vedic_rca #(.N(2*N)) u_fin (.x({hh, ll}), .y(mid_sh), .s(z));
    end
endmodule

module vedic_mul_seq #(parameter int W = 16) (
    input  logic           clk,
    input  logic           rst_n,
    vedic_mul_seq_if.slave bus
);
    localparam int H = W/2;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_r, b_r;
    logic [2*W-1:0] acc, p_r;
    logic [1:0]     q;
    logic           neg_r;
    logic           in_ready_r, out_valid_r, busy_r;

    logic [H-1:0]   cx, cy;
    logic [W-1:0]   pp;
    logic [2*W-1:0] pp_sh, acc_nxt;
    logic [W-1:0]   a_in, b_in;
    logic           neg_in;

`ifdef VEDIC_SIGNED_EN
    // Negating -2^(W-1) wraps to 2^(W-1), which is the correct unsigned magnitude
    assign a_in   = (bus.signed_mode && bus.a[W-1]) ? -bus.a : bus.a;
    assign b_in   = (bus.signed_mode && bus.b[W-1]) ? -bus.b : bus.b;
    assign neg_in = bus.signed_mode & (bus.a[W-1] ^ bus.b[W-1]);
`else
    assign a_in   = bus.a;
    assign b_in   = bus.b;
    assign neg_in = 1'b0;
`endif

    // q[0] picks the high half of a, q[1] the high half of b
    assign cx = q[0] ? a_r[W-1:H] : a_r[H-1:0];
    assign cy = q[1] ? b_r[W-1:H] : b_r[H-1:0];

    vedic_core #(.N(H)) u_core (.x(cx), .y(cy), .z(pp));

    always_comb begin
        pp_sh = '0;
        case (q)
            2'd0:    pp_sh = {{W{1'b0}}, pp};
            2'd3:    pp_sh = {pp, {W{1'b0}}};
            default: pp_sh = {{H{1'b0}}, pp, {H{1'b0}}};
        endcase
    end

    assign acc_nxt = acc + pp_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            acc         <= '0;
            p_r         <= '0;
            q           <= '0;
            neg_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_r        <= a_in;
                    b_r        <= b_in;
                    neg_r      <= neg_in;
                    acc        <= '0;
                    q          <= '0;
                    state      <= CALC;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b1;
                end
                CALC: begin
                    acc <= acc_nxt;
                    q   <= q + 2'd1;
                    if (q == 2'd3) begin
                        p_r         <= neg_r ? -acc_nxt : acc_nxt;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.p         = p_r;
endmodule

// File: tb/tb_vedic_mul_seq.sv
// Scoreboard bench for vedic_mul_seq: W=8 directed/stall/reset cases, W=32 directed plus random.
module tb_vedic_mul_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vedic_mul_seq_if #(.W(8))  if8 ();
    vedic_mul_seq_if #(.W(32)) if32 ();

    vedic_mul_seq #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    vedic_mul_seq #(.W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;
    bit rnd_on   = 1'b0;
    bit ov8_q, ov32_q;

    logic [15:0] exp8[$];
    logic [63:0] exp32[$];
    int          lat8[$];
    int          lat32[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitors sample 2 time units after the falling edge, clear of input changes
    always @(negedge clk) begin
        #2;
        if (!rst_n) ov8_q = 1'b0;
        else begin
            if (if8.out_valid && !ov8_q) begin
                if (lat8.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL spurious8: out_valid with no accepted transaction at cycle %0d", cyc);
                end else check("latency8", 64'(cyc - lat8.pop_front()), 64'd4);
            end
            if (if8.out_valid && if8.out_ready && exp8.size() != 0)
                check("p8", 64'(if8.p), 64'(exp8.pop_front()));
            ov8_q = if8.out_valid;
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst_n) ov32_q = 1'b0;
        else begin
            if (if32.out_valid && !ov32_q) begin
                if (lat32.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL spurious32: out_valid with no accepted transaction at cycle %0d", cyc);
                end else check("latency32", 64'(cyc - lat32.pop_front()), 64'd4);
            end
            if (if32.out_valid && if32.out_ready && exp32.size() != 0)
                check("p32", if32.p, exp32.pop_front());
            ov32_q = if32.out_valid;
        end
    end

    always @(negedge clk) if32.out_ready = rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;

    // Called on a falling edge; returns on the falling edge after acceptance
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                         input logic [15:0] exp, input bit track);
        int n = 0;
        while (!if8.in_ready && n < 100) begin @(negedge clk); n++; end
        if (!if8.in_ready) begin
            tot_cnt++;
            $display("FAIL accept8: in_ready stayed low for %0d cycles", n);
            return;
        end
        if8.a = a; if8.b = b; if8.in_valid = 1'b1;
`ifdef VEDIC_SIGNED_EN
        if8.signed_mode = sm;
`endif
        if (sm) begin end
        if (track) begin
            exp8.push_back(exp);
            lat8.push_back(cyc + 1);
        end
        @(negedge clk);
        if8.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int n = 0;
        while (!if32.in_ready && n < 200) begin @(negedge clk); n++; end
        if (!if32.in_ready) begin
            tot_cnt++;
            $display("FAIL accept32: in_ready stayed low for %0d cycles", n);
            return;
        end
        if32.a = a; if32.b = b; if32.in_valid = 1'b1;
        exp32.push_back(exp);
        lat32.push_back(cyc + 1);
        @(negedge clk);
        if32.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp8.size() != 0 || exp32.size() != 0) && n < 500) begin @(negedge clk); n++; end
        if (exp8.size() != 0 || exp32.size() != 0) begin
            tot_cnt++;
            $display("FAIL %s: %0d/%0d products never delivered", name, exp8.size(), exp32.size());
            exp8.delete(); exp32.delete();
        end
    endtask

    task automatic wait_ov8(input string name);
        int n = 0;
        while (!if8.out_valid && n < 20) begin @(negedge clk); n++; end
        if (!if8.out_valid) begin
            tot_cnt++;
            $display("FAIL %s: out_valid never rose", name);
        end
    endtask

    logic [7:0]  va[5] = '{8'd0,  8'd1,   8'd128,   8'd170,     8'd255};
    logic [7:0]  vb[5] = '{8'd0,  8'd255, 8'd2,     8'd85,      8'd1};
    logic [15:0] vp[5] = '{16'h0, 16'hFF, 16'h0100, 16'h3872,   16'h00FF};

    logic [31:0] wa[4] = '{32'h1234, 32'hFFFF, 32'hFFFF_FFFF,           32'h0001_0000};
    logic [31:0] wb[4] = '{32'h0,    32'h1,    32'hFFFF_FFFF,           32'h0001_0000};
    logic [63:0] wp[4] = '{64'h0,    64'hFFFF, 64'hFFFF_FFFE_0000_0001, 64'h1_0000_0000};

    initial begin
        logic [31:0] ra, rb;
        if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.out_ready = 1'b1;
        if32.in_valid = 1'b0; if32.a = '0; if32.b = '0;
`ifdef VEDIC_SIGNED_EN
        if8.signed_mode = 1'b0; if32.signed_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(if8.out_valid), 64'd0);
        check("rst_busy",      64'(if8.busy),      64'd0);
        check("rst_p",         64'(if8.p),         64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  64'(if8.in_ready),  64'd1);
        check("rst_p32",       if32.p,             64'd0);

        // 255*255, then back in IDLE one cycle after the handshake
        send8(8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1);
        wait_ov8("ov_ff");
        @(negedge clk);
        check("idle_after_done_ready", 64'(if8.in_ready), 64'd1);
        check("idle_after_done_busy",  64'(if8.busy),     64'd0);

        for (int i = 0; i < 5; i++) send8(va[i], vb[i], 1'b0, vp[i], 1'b1);
        drain("drain_dir8");

        // Consumer stalls 10 cycles; product and handshake must hold, new operands ignored
        if8.out_ready = 1'b0;
        send8(8'd13, 8'd11, 1'b0, 16'd143, 1'b1);
        wait_ov8("ov_stall");
        for (int i = 0; i < 10; i++) begin
            check("stall_p",        64'(if8.p),         64'd143);
            check("stall_valid",    64'(if8.out_valid), 64'd1);
            check("stall_in_ready", 64'(if8.in_ready),  64'd0);
            if8.in_valid = 1'b1; if8.a = 8'd99; if8.b = 8'd7;
            @(negedge clk);
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        drain("drain_stall");
        @(negedge clk);

        // Reset in the second CALC cycle discards the transaction
        send8(8'd50, 8'd3, 1'b0, 16'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(if8.out_valid), 64'd0);
        check("midrst_busy",      64'(if8.busy),      64'd0);
        check("midrst_p",         64'(if8.p),         64'd0);
        check("midrst_in_ready",  64'(if8.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_output", 64'(if8.out_valid), 64'd0);
        send8(8'd2, 8'd3, 1'b0, 16'd6, 1'b1);
        drain("drain_rst");

`ifdef VEDIC_SIGNED_EN
        send8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        send8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1);
        send8(8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b1);
        drain("drain_signed");
`endif

        for (int i = 0; i < 4; i++) send32(wa[i], wb[i], wp[i]);
        drain("drain_dir32");

        rnd_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            send32(ra, rb, {32'd0, ra} * {32'd0, rb});
        end
        drain("drain_rnd32");
        rnd_on = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vedic_mul_seq.md
VEDIC_MUL_SEQ -- requirements
Module: vedic_mul_seq

Interface
REQ-001 SHALL have parameter W, default 16, meaning operand width in bits; legal values 4, 8, 16, 32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning operands a/b are valid this cycle.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts operands this cycle.
REQ-006 SHALL have port a, input, W, multiplicand.
REQ-007 SHALL have port b, input, W, multiplier.
REQ-008 SHALL have port out_valid, output, 1, meaning the product is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer takes the product this cycle.
REQ-010 SHALL have port p, output, 2W, product.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL compute p with one combinational (W/2)x(W/2) Vedic core, recursively built from 2x2 Vedic cells and ripple adders, reused over four cycles.
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 SHALL, on an edge with in_valid && in_ready, register a and b, clear the 2W-bit accumulator, set quadrant counter q = 0, go to CALC.
REQ-015 SHALL, in CALC, add per edge one zero-extended partial product: q0 aL*bL shift 0; q1 aH*bL shift W/2; q2 aL*bH shift W/2; q3 aH*bH shift W; q then increments.
REQ-016 SHALL go CALC->DONE on the edge that adds q3; out_valid rises 4 cycles after the acceptance cycle (fixed latency, independent of operand values).
REQ-017 SHALL hold p and out_valid stable in DONE until out_valid && out_ready, then go to IDLE on that edge.
REQ-018 SHALL ignore a, b and in_valid while not in IDLE; operand registers do not change.
REQ-019 SHALL perform all accumulation modulo 2^(2W); no overflow is possible, and no carry-out port exists.
REQ-020 SHALL keep p at its last value outside DONE; p is defined only while out_valid = 1.
REQ-021 SHALL support no back-to-back acceptance: minimum 6-cycle initiation interval with out_ready held high (accept, 4 CALC, DONE, then IDLE).

Reset
REQ-022 SHALL, on rst_n low, immediately force state IDLE, q = 0, accumulator = 0, operand registers = 0, p = 0, out_valid = 0, busy = 0; in_ready = 1 once rst_n is high.
REQ-023 SHALL, on reset during CALC or DONE, discard the transaction; no out_valid is produced for it.

Configuration
REQ-024 SHALL, with macro VEDIC_SIGNED_EN defined, add input port signed_mode (1 bit, sampled with operands at acceptance): when 1, a and b are two's complement, magnitudes are multiplied, and the accumulated result is negated at the CALC->DONE edge if the operand signs differ.
REQ-025 SHALL, without VEDIC_SIGNED_EN, have no signed_mode port and treat operands as unsigned only.
REQ-026 SHALL, under VEDIC_SIGNED_EN, handle magnitude 2^(W-1) of -2^(W-1) correctly in W unsigned bits; latency remains per REQ-016.

Verification
REQ-027 W=8: accept a=255, b=255, out_ready=1 -> out_valid 4 cycles after acceptance, p=0xFE01, then IDLE one cycle later.
REQ-028 W=16: a=0x1234, b=0x0000 -> p=0x00000000; then a=0xFFFF, b=0x0001 -> p=0x0000FFFF; latency 4 both.
REQ-029 W=8, a=13, b=11, out_ready low 10 cycles -> p=143 held stable with out_valid high; in_ready low; new in_valid ignored.
REQ-030 W=8: rst_n pulsed low in the 2nd CALC cycle -> all outputs reset value immediately, no out_valid; next a=2, b=3 -> p=6.
REQ-031 W=8, VEDIC_SIGNED_EN, signed_mode=1: a=-128, b=-128 -> p=16384; a=-3, b=5 -> p=0xFFF1; signed_mode=0, a=0xFD, b=5 -> p=0x04F1.
REQ-032 W=32: 1000 random operand pairs with random out_ready -> every p equals the reference a*b, and every accepted transaction yields exactly one output.
